multu_hilo: RTL and testbench

- Sequential unsigned 32x32 shift-add multiplier with architectural HI/LO registers.
- Sits in the EX stage beside the combinational shifter/ALU, on the result path into EX/MEM.
- Consumes operands from the ID/EX register, iterates with a 1-bit logical right shift of a 64-bit product register each cycle, and provides HI/LO for mfhi/mflo.
- Raises busy so the hazard unit stalls the front of the pipeline.

---
 rtl/multu_hilo_pkg.sv | 25 ++
 rtl/multu_hilo_mul_datapath.sv | 65 ++++++
 rtl/multu_hilo.sv | 103 ++++++++++
 tb/tb_multu_hilo.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/multu_hilo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : multu_hilo_pkg
//  Description : Shared constants for the sequential unsigned multiplier
//                with architectural HI/LO registers. Holds the default
//                operand width, the fixed iteration count and the
//                controller state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package multu_hilo_pkg;

    // Default operand width; the product is twice this wide.
    localparam int MUL_WIDTH   = 32;
    // One shift-add step per multiplier bit, independent of operand value.
    localparam int ITER_COUNT  = 32;
    // Default iteration counter width (2**6 > 32).
    localparam int MUL_CNT_W   = 6;

    // Controller state encoding.
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

endpackage : multu_hilo_pkg
`default_nettype wire

// File: rtl/multu_hilo_mul_datapath.sv
`default_nettype none
// ============================================================================
//  Module      : mul_datapath
//  Description : Shift-add datapath. Holds the captured multiplicand, the
//                2*WIDTH-bit product/multiplier shift register, the
//                (WIDTH+1)-bit adder and the iteration counter.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                load            - capture dataA/dataB and clear the counter
//                step            - perform one shift-add iteration
//                dataA, dataB    - multiplicand, multiplier
//                prod_next       - product register value after this step
//                last            - this step is the final iteration
//  Revision    : 1.0  initial release
// ============================================================================
module mul_datapath
    import multu_hilo_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH,
    parameter int CNT_W = MUL_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 step,
    input  logic [WIDTH-1:0]     dataA,
    input  logic [WIDTH-1:0]     dataB,
    output logic [2*WIDTH-1:0]   prod_next,
    output logic                 last
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH);

    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] prod;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic [WIDTH:0]     sum;

    // The carry out of the add becomes the new MSB, so the right shift
    // never loses product bits and needs no separate zero fill.
    always_comb begin
        sum       = {1'b0, prod[2*WIDTH-1:WIDTH]}
                  + (prod[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
        prod_next = {sum, prod[WIDTH-1:1]};
        cnt_next  = cnt + 1'b1;
        last      = step && (cnt_next == LAST_CNT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand <= '0;
            prod  <= '0;
            cnt   <= '0;
        end else if (load) begin
            mcand <= dataA;
            prod  <= {{WIDTH{1'b0}}, dataB};
            cnt   <= '0;
        end else if (step) begin
            prod  <= prod_next;
            cnt   <= cnt_next;
        end
    end

endmodule : mul_datapath
`default_nettype wire

// File: rtl/multu_hilo.sv
`default_nettype none
// ============================================================================
//  Module      : multu_hilo
//  Description : Sequential unsigned WIDTHxWIDTH multiplier with HI/LO
//                registers for the EX stage. A start in IDLE runs WIDTH
//                shift-add iterations, then commits the full product to
//                HI/LO and pulses done. mthi/mtlo writes are taken in IDLE.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                start           - begin dataA*dataB (IDLE only)
//                dataA, dataB    - multiplicand / multiplier; dataA also
//                                  feeds mthi/mtlo
//                wr_hi, wr_lo    - load HI / LO from dataA (IDLE only)
//                sel_hi          - read select for hilo_out
//                busy            - iterating; stalls the front end
//                done            - one-cycle pulse when HI/LO updated
//                hi, lo          - architectural HI / LO
//                hilo_out        - sel_hi ? hi : lo
//  Revision    : 1.0  initial release
// ============================================================================
module multu_hilo
    import multu_hilo_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH,
    parameter int CNT_W = MUL_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   dataA,
    input  logic [WIDTH-1:0]   dataB,
    input  logic               wr_hi,
    input  logic               wr_lo,
    input  logic               sel_hi,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo,
    output logic [WIDTH-1:0]   hilo_out
);

    logic [1:0]         state;
    logic               dp_load;
    logic               dp_step;
    logic [2*WIDTH-1:0] prod_next;
    logic               last;

    assign dp_load  = (state == ST_IDLE) && start;
    assign dp_step  = (state == ST_RUN);
    assign busy     = (state == ST_RUN);
    assign done     = (state == ST_DONE);
    assign hilo_out = sel_hi ? hi : lo;

    mul_datapath #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_datapath (
        .clk       (clk),
        .rst       (rst),
        .load      (dp_load),
        .step      (dp_step),
        .dataA     (dataA),
        .dataB     (dataB),
        .prod_next (prod_next),
        .last      (last)
    );

    // HI/LO change only on a committed product or an IDLE mthi/mtlo, so a
    // reset during RUN leaves no partial result behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            hi    <= '0;
            lo    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        // start takes priority; concurrent writes are dropped
                        state <= ST_RUN;
                    end else begin
                        if (wr_hi) hi <= dataA;
                        if (wr_lo) lo <= dataA;
                    end
                end
                ST_RUN: begin
                    if (last) begin
                        hi    <= prod_next[2*WIDTH-1:WIDTH];
                        lo    <= prod_next[WIDTH-1:0];
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : multu_hilo
`default_nettype wire

// File: tb/tb_multu_hilo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multu_hilo
//  Description : Directed self-checking bench for multu_hilo with
//                hand-computed expected products and control behaviour.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_multu_hilo;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic        wr_hi;
    logic        wr_lo;
    logic        sel_hi;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] hilo_out;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    multu_hilo dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .dataA    (dataA),
        .dataB    (dataB),
        .wr_hi    (wr_hi),
        .wr_lo    (wr_lo),
        .sel_hi   (sel_hi),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo),
        .hilo_out (hilo_out)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count cycles of busy until it drops (bounded); returns busy-high count.
    task automatic wait_busy(output int n);
        n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        dataA = a; dataB = b; start = 1'b1;
        tick();
        start = 1'b0;
        dataA = 32'hA5A5_A5A5; dataB = 32'h5A5A_5A5A;   // must be ignored
        check({tag, "_busy0"}, 64'(busy), 64'd1);
        wait_busy(n);
        check({tag, "_busycycles"}, 64'(n), 64'd32);
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_hi"}, 64'(hi), 64'(exp_hi));
        check({tag, "_lo"}, 64'(lo), 64'(exp_lo));
        tick();
        check({tag, "_done_clr"}, 64'(done), 64'd0);
    endtask

    initial begin
        int n;
        int pulses;
        rst = 1'b1; start = 1'b0; dataA = '0; dataB = '0;
        wr_hi = 1'b0; wr_lo = 1'b0; sel_hi = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hi",   64'(hi),   64'd0);
        check("rst_lo",   64'(lo),   64'd0);

        run_mul("m3x5",  32'd3,          32'd5,          32'h0000_0000, 32'h0000_000F);
        run_mul("mffff", 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE, 32'h0000_0001);
        run_mul("m8x2",  32'h8000_0000,  32'd2,          32'h0000_0001, 32'h0000_0000);
        run_mul("m0",    32'd0,          32'h1234_5678,  32'h0000_0000, 32'h0000_0000);

        // Second start during RUN is ignored; exactly one done pulse.
        dataA = 32'd7; dataB = 32'd9; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        dataA = 32'd2; dataB = 32'd2; start = 1'b1;
        tick();
        start = 1'b0;
        pulses = 0;
        for (int i = 0; i < 50; i++) begin
            if (done) begin
                pulses++;
                check("restart_hi", 64'(hi), 64'd0);
                check("restart_lo", 64'(lo), 64'd63);
            end
            tick();
        end
        check("restart_pulses", 64'(pulses), 64'd1);
        check("restart_idle", 64'(busy), 64'd0);

        // mthi, then reset in the middle of a multiply.
        dataA = 32'h1234_5678; wr_hi = 1'b1;
        tick();
        wr_hi = 1'b0;
        check("mthi", 64'(hi), 64'h1234_5678);
        dataA = 32'd4; dataB = 32'd4; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_hi",   64'(hi),   64'd0);
        check("abort_lo",   64'(lo),   64'd0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (done || busy) pulses++;
            tick();
        end
        check("abort_quiet", 64'(pulses), 64'd0);

        // mtlo and both writes together.
        dataA = 32'hCAFE_BABE; wr_lo = 1'b1; sel_hi = 1'b0;
        tick();
        wr_lo = 1'b0;
        check("mtlo", 64'(lo), 64'hCAFE_BABE);
        check("hilo_lo", 64'(hilo_out), 64'hCAFE_BABE);
        check("mtlo_hi_kept", 64'(hi), 64'd0);
        dataA = 32'h0BAD_F00D; wr_hi = 1'b1; wr_lo = 1'b1;
        tick();
        wr_hi = 1'b0; wr_lo = 1'b0;
        check("both_hi", 64'(hi), 64'h0BAD_F00D);
        check("both_lo", 64'(lo), 64'h0BAD_F00D);
        sel_hi = 1'b1;
        #1;
        check("hilo_hi", 64'(hilo_out), 64'h0BAD_F00D);

        // mthi during RUN is ignored; HI/LO hold until commit.
        dataA = 32'h0001_0000; dataB = 32'h0001_0000; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        dataA = 32'hDEAD_BEEF; wr_hi = 1'b1; wr_lo = 1'b1;
        tick();
        wr_hi = 1'b0; wr_lo = 1'b0;
        check("run_hi_hold", 64'(hi), 64'h0BAD_F00D);
        check("run_lo_hold", 64'(lo), 64'h0BAD_F00D);
        wait_busy(n);
        check("run_done", 64'(done), 64'd1);
        check("run_hi", 64'(hi), 64'd1);
        check("run_lo", 64'(lo), 64'd0);
        check("run_hilo", 64'(hilo_out), 64'd1);
        // wr in DONE is ignored as well
        wr_hi = 1'b1;
        tick();
        wr_hi = 1'b0;
        check("done_wr_ignored", 64'(hi), 64'd1);

        // start and mthi in the same IDLE cycle: start wins.
        dataA = 32'd6; dataB = 32'd7; start = 1'b1; wr_hi = 1'b1;
        tick();
        start = 1'b0; wr_hi = 1'b0;
        check("sw_hi_dropped", 64'(hi), 64'd1);
        check("sw_busy", 64'(busy), 64'd1);
        wait_busy(n);
        check("sw_done", 64'(done), 64'd1);
        check("sw_hi", 64'(hi), 64'd0);
        check("sw_lo", 64'(lo), 64'd42);

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_multu_hilo
`default_nettype wire
